// File: rtl/imm_pkg.sv
// Shared definitions for the immediate prefix extender slice.
// Holds the mode encodings, default widths, the accumulator state
// encoding and the masking / extension helpers used by the top level.
// Optional feature macro used by this slice: IMM_PREFIX_EN.
package imm_pkg;

  typedef enum logic [1:0] {
    IMM_SHORT_SIGN = 2'b00,
    IMM_LONG_SIGN  = 2'b01,
    IMM_LONG_ZERO  = 2'b10,
    IMM_PREFIX     = 2'b11
  } imm_mode_e;

  typedef enum logic {
    ACC_IDLE  = 1'b0,
    ACC_ACCUM = 1'b1
  } acc_state_e;

  localparam int DATA_W_DEF     = 8;
  localparam int FIELD_W_DEF    = 6;
  localparam int SHORT_W_DEF    = 3;
  localparam int MAX_PREFIX_DEF = 1;

  // Working width for the combined immediate before it is cut to DATA_W.
  localparam int EXT_MAX_W = 64;

  typedef logic [EXT_MAX_W-1:0] ext_word_t;

  // Mask with the low 'width' bits set.
  function automatic ext_word_t low_mask(input int width);
    ext_word_t res;
    if (width >= EXT_MAX_W) begin
      res = '1;
    end else begin
      res = (ext_word_t'(1'b1) << width) - ext_word_t'(1'b1);
    end
    return res;
  endfunction

  // Extend the low src_width bits of value, replicating the top source
  // bit when signed_flag is set and zero-filling otherwise. The caller
  // keeps the low DATA_W bits of the result.
  function automatic ext_word_t ext_fn(input ext_word_t value,
                                       input int        src_width,
                                       input logic      signed_flag);
    ext_word_t mask;
    ext_word_t top_bit;
    logic      fill;
    mask = low_mask(src_width);
    if (src_width > 0 && src_width <= EXT_MAX_W) begin
      top_bit = value >> (src_width - 1);
      fill    = signed_flag & top_bit[0];
    end else begin
      top_bit = '0;
      fill    = 1'b0;
    end
    if (fill) begin
      return (value & mask) | ~mask;
    end else begin
      return value & mask;
    end
  endfunction

endpackage

// File: rtl/imm_prefix_extender_if.sv
// Decode-to-extender bus for imm_prefix_extender.
// master: decode side (drives instruction, mode, stall, flush).
// slave : extender side (drives imm_valid/imm_value and prefix status).
interface imm_prefix_extender_if
  import imm_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int FIELD_W = FIELD_W_DEF
);
  logic               in_valid;
  logic [FIELD_W-1:0] instr_field;
  logic [1:0]         mode;
  logic               stall;
  logic               flush;
  logic               imm_valid;
  logic [DATA_W-1:0]  imm_value;
  logic               prefix_pending;
  logic               prefix_ovf;

  modport master (
    output in_valid, instr_field, mode, stall, flush,
    input  imm_valid, imm_value, prefix_pending, prefix_ovf
  );

  modport slave (
    input  in_valid, instr_field, mode, stall, flush,
    output imm_valid, imm_value, prefix_pending, prefix_ovf
  );
endinterface

// File: rtl/imm_prefix_acc.sv
// Prefix accumulator: collects FIELD_W chunks from prefix instructions,
// tracks how many are held, and flags an overflow when a prefix arrives
// while already full (the oldest chunk is dropped).
// Ports: Clk, Rst_n (async active-low); flush, stall; push (prefix
// accepted), clear (immediate consumed), field; outputs acc, count,
// prefix_pending, prefix_ovf (one-cycle pulse).
module imm_prefix_acc
  import imm_pkg::*;
#(
  parameter int FIELD_W    = FIELD_W_DEF,
  parameter int MAX_PREFIX = MAX_PREFIX_DEF,
  localparam int ACC_W     = MAX_PREFIX * FIELD_W,
  localparam int CNT_W     = $clog2(MAX_PREFIX + 1)
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               flush,
  input  logic               stall,
  input  logic               push,
  input  logic               clear,
  input  logic [FIELD_W-1:0] field,
  output logic [ACC_W-1:0]   acc,
  output logic [CNT_W-1:0]   count,
  output logic               prefix_pending,
  output logic               prefix_ovf
);

  logic [ACC_W-1:0]         acc_r,   acc_nxt_s;
  logic [CNT_W-1:0]         count_r, count_nxt_s;
  logic                     ovf_r,   ovf_nxt_s;
  logic [ACC_W+FIELD_W-1:0] shifted_s;
  logic                     full_s;
  acc_state_e               state_s;

  // State register: accumulator, chunk count and overflow pulse.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      acc_r   <= '0;
      count_r <= '0;
      ovf_r   <= 1'b0;
    end else begin
      acc_r   <= acc_nxt_s;
      count_r <= count_nxt_s;
      ovf_r   <= ovf_nxt_s;
    end
  end

  // Next-state logic, flush over stall over normal operation.
  always_comb begin
    acc_nxt_s   = acc_r;
    count_nxt_s = count_r;
    ovf_nxt_s   = 1'b0;
    full_s      = (count_r == CNT_W'(MAX_PREFIX));
    shifted_s   = {acc_r, field};
    if (flush) begin
      acc_nxt_s   = '0;
      count_nxt_s = '0;
    end else if (stall) begin
      acc_nxt_s   = acc_r;
    end else if (push) begin
      // New chunk enters on the LSB side; the top chunk falls off when full.
      acc_nxt_s   = shifted_s[ACC_W-1:0];
      ovf_nxt_s   = full_s;
      if (full_s) begin
        count_nxt_s = count_r;
      end else begin
        count_nxt_s = count_r + CNT_W'(1);
      end
    end else if (clear) begin
      acc_nxt_s   = '0;
      count_nxt_s = '0;
    end else begin
      acc_nxt_s   = acc_r;
    end
  end

  // Accumulator state is a direct function of the held chunk count.
  always_comb begin
    if (count_r != '0) begin
      state_s = ACC_ACCUM;
    end else begin
      state_s = ACC_IDLE;
    end
  end

  assign acc            = acc_r;
  assign count          = count_r;
  assign prefix_ovf     = ovf_r;
  assign prefix_pending = (state_s == ACC_ACCUM);

endmodule

// File: rtl/imm_prefix_extender.sv
// Registered immediate generator between decode and the ALU B-mux.
// Modes: 00 short-sign, 01 long-sign, 10 long-zero, 11 prefix. An
// instruction accepted on an edge appears on imm_value/imm_valid after
// that edge. Prefix chunks held in imm_prefix_acc are placed above the
// base field when an immediate is consumed.
// Ports: Clk, Rst_n (async active-low), bus (imm_prefix_extender_if.slave).
// Macro IMM_PREFIX_EN: when defined the prefix accumulator is built; when
// undefined mode 11 is illegal (no output, value held) and the prefix
// status outputs are tied low.
module imm_prefix_extender
  import imm_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIELD_W    = FIELD_W_DEF,
  parameter int SHORT_W    = SHORT_W_DEF,
  parameter int MAX_PREFIX = MAX_PREFIX_DEF
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  imm_prefix_extender_if.slave bus
);

  localparam int ACC_W = MAX_PREFIX * FIELD_W;
  localparam int CNT_W = $clog2(MAX_PREFIX + 1);

  logic [ACC_W-1:0]  acc_s;
  logic [CNT_W-1:0]  count_s;
  logic              consume_s;
  logic              signed_s;
  int                base_w_s;
  int                src_w_s;
  ext_word_t         base_s;
  ext_word_t         comb_s;
  logic [DATA_W-1:0] ext_s;
  logic              imm_valid_r;
  logic [DATA_W-1:0] imm_value_r;

  assign consume_s = bus.in_valid & (bus.mode != IMM_PREFIX);

`ifdef IMM_PREFIX_EN
  logic push_s;

  assign push_s = bus.in_valid & (bus.mode == IMM_PREFIX);

  imm_prefix_acc #(
    .FIELD_W   (FIELD_W),
    .MAX_PREFIX(MAX_PREFIX)
  ) u_acc (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .flush         (bus.flush),
    .stall         (bus.stall),
    .push          (push_s),
    .clear         (consume_s),
    .field         (bus.instr_field),
    .acc           (acc_s),
    .count         (count_s),
    .prefix_pending(bus.prefix_pending),
    .prefix_ovf    (bus.prefix_ovf)
  );
`else
  assign acc_s              = '0;
  assign count_s            = '0;
  assign bus.prefix_pending = 1'b0;
  assign bus.prefix_ovf     = 1'b0;
`endif

  // Base field selection and extension mode decode.
  always_comb begin
    if (bus.mode == IMM_SHORT_SIGN) begin
      base_s   = ext_word_t'(bus.instr_field[SHORT_W-1:0]);
      base_w_s = SHORT_W;
    end else begin
      base_s   = ext_word_t'(bus.instr_field);
      base_w_s = FIELD_W;
    end
    signed_s = (bus.mode != IMM_LONG_ZERO);
  end

  // Combine held prefix chunks above the base; the source width follows
  // the live chunk count, so the sign bit moves up as prefixes accumulate.
  always_comb begin
    src_w_s = int'(count_s) * FIELD_W + base_w_s;
    comb_s  = ((ext_word_t'(acc_s) & low_mask(int'(count_s) * FIELD_W)) << base_w_s)
              | base_s;
    ext_s   = DATA_W'(ext_fn(comb_s, src_w_s, signed_s));
  end

  // Output register: flush over stall over normal; value holds unless consumed.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      imm_valid_r <= 1'b0;
      imm_value_r <= '0;
    end else if (bus.flush) begin
      imm_valid_r <= 1'b0;
    end else if (bus.stall) begin
      imm_valid_r <= imm_valid_r;
    end else if (consume_s) begin
      imm_valid_r <= 1'b1;
      imm_value_r <= ext_s;
    end else begin
      imm_valid_r <= 1'b0;
    end
  end

  assign bus.imm_valid = imm_valid_r;
  assign bus.imm_value = imm_value_r;

endmodule

// File: tb/tb_imm_prefix_extender.sv
// Self-checking bench for imm_prefix_extender (default parameters).
// A behavioural model computes the expected outputs when stimulus is
// driven; the expectation is queued and compared one edge later.
module tb_imm_prefix_extender;

`ifdef IMM_PREFIX_EN
  localparam bit PREFIX_EN = 1'b1;
`else
  localparam bit PREFIX_EN = 1'b0;
`endif
  localparam int MAXP = 1;

  typedef struct {
    logic       valid;
    logic [7:0] value;
    logic       pending;
    logic       ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  // model state
  int         m_acc;
  int         m_cnt;
  logic       m_valid;
  logic [7:0] m_value;
  logic       m_ovf;

  imm_prefix_extender_if #(.DATA_W(8), .FIELD_W(6)) bus ();

  imm_prefix_extender #(
    .DATA_W(8), .FIELD_W(6), .SHORT_W(3), .MAX_PREFIX(MAXP)
  ) dut (
    .Clk  (clk),
    .Rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_cnt = 0; m_valid = 1'b0; m_value = 8'h00; m_ovf = 1'b0;
  endtask

  task automatic model_step(input logic iv, input logic [5:0] f, input logic [1:0] m,
                            input logic st, input logic fl);
    int     bw;
    int     w;
    longint c;
    if (fl) begin
      m_valid = 1'b0; m_ovf = 1'b0; m_acc = 0; m_cnt = 0;
    end else if (st) begin
      m_ovf = 1'b0;
    end else if (!iv) begin
      m_valid = 1'b0; m_ovf = 1'b0;
    end else if (m == 2'd3) begin
      m_valid = 1'b0;
      if (PREFIX_EN) begin
        m_ovf = (m_cnt == MAXP);
        m_acc = ((m_acc * 64) + int'(f)) % (1 << (6 * MAXP));
        if (m_cnt < MAXP) m_cnt = m_cnt + 1;
      end else begin
        m_ovf = 1'b0;
      end
    end else begin
      bw = (m == 2'd0) ? 3 : 6;
      w  = m_cnt * 6 + bw;
      c  = longint'(m_acc) * (longint'(1) << bw) + longint'(int'(f) % (1 << bw));
      if (m != 2'd2 && ((c >> (w - 1)) & 64'sd1) != 0)
        c = c - (longint'(1) << w);
      m_value = 8'(c);
      m_valid = 1'b1; m_ovf = 1'b0; m_acc = 0; m_cnt = 0;
    end
  endtask

  // Drive one cycle, queue the model's expectation, compare after the edge.
  task automatic step(input logic iv, input logic [5:0] f, input logic [1:0] m,
                      input logic st, input logic fl);
    exp_t e;
    @(negedge clk);
    bus.in_valid = iv; bus.instr_field = f; bus.mode = m;
    bus.stall = st; bus.flush = fl;
    model_step(iv, f, m, st, fl);
    e.valid = m_valid; e.value = m_value; e.pending = (m_cnt != 0); e.ovf = m_ovf;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("imm_valid",      32'(bus.imm_valid),      32'(e.valid));
    chk("imm_value",      32'(bus.imm_value),      32'(e.value));
    chk("prefix_pending", 32'(bus.prefix_pending), 32'(e.pending));
    chk("prefix_ovf",     32'(bus.prefix_ovf),     32'(e.ovf));
  endtask

  task automatic idle();
    step(1'b0, 6'd0, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.instr_field = 6'd0; bus.mode = 2'd0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    model_reset();
    #3;
    chk("rst_valid",   32'(bus.imm_valid),      32'd0);
    chk("rst_value",   32'(bus.imm_value),      32'd0);
    chk("rst_pending", 32'(bus.prefix_pending), 32'd0);
    chk("rst_ovf",     32'(bus.prefix_ovf),     32'd0);
    #9 rst_n = 1'b1;
    idle();

    // Plain extension modes
    step(1'b1, 6'b000101, 2'b00, 1'b0, 1'b0);
    chk("short_sign_fd", 32'(bus.imm_value), 32'h0000_00FD);
    step(1'b1, 6'b100000, 2'b01, 1'b0, 1'b0);
    chk("long_sign_e0", 32'(bus.imm_value), 32'h0000_00E0);
    step(1'b1, 6'b100000, 2'b10, 1'b0, 1'b0);
    chk("long_zero_20", 32'(bus.imm_value), 32'h0000_0020);

    // Prefix chain (mode 11 is illegal in the reduced build)
    step(1'b1, 6'b000011, 2'b11, 1'b0, 1'b0);
    chk("prefix_no_valid", 32'(bus.imm_valid), 32'd0);
    chk("prefix_value_held", 32'(bus.imm_value), 32'h0000_0020);
    idle();
    step(1'b1, 6'b000001, 2'b01, 1'b0, 1'b0);
`ifdef IMM_PREFIX_EN
    chk("prefix_chain_c1", 32'(bus.imm_value), 32'h0000_00C1);
`else
    chk("noprefix_chain_01", 32'(bus.imm_value), 32'h0000_0001);
`endif

    // Overflow: second prefix pushes out the first
    step(1'b1, 6'b111111, 2'b11, 1'b0, 1'b0);
    step(1'b1, 6'b000010, 2'b11, 1'b0, 1'b0);
`ifdef IMM_PREFIX_EN
    chk("ovf_pulse", 32'(bus.prefix_ovf), 32'd1);
`else
    chk("ovf_tied", 32'(bus.prefix_ovf), 32'd0);
`endif
    step(1'b1, 6'b000000, 2'b10, 1'b0, 1'b0);
`ifdef IMM_PREFIX_EN
    chk("ovf_consume_80", 32'(bus.imm_value), 32'h0000_0080);
`else
    chk("noprefix_zero_00", 32'(bus.imm_value), 32'h0000_0000);
`endif

    // Flush discards prefix and same-cycle instruction
    step(1'b1, 6'b000011, 2'b11, 1'b0, 1'b0);
    step(1'b1, 6'b000001, 2'b01, 1'b0, 1'b1);
    step(1'b1, 6'b111111, 2'b01, 1'b0, 1'b0);
    chk("after_flush_ff", 32'(bus.imm_value), 32'h0000_00FF);

    // Stall for three cycles mid-accumulation
    step(1'b1, 6'b000011, 2'b11, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 6'b010101, 2'b10, 1'b1, 1'b0);
    step(1'b1, 6'b000001, 2'b01, 1'b0, 1'b0);
`ifdef IMM_PREFIX_EN
    chk("stall_consume_c1", 32'(bus.imm_value), 32'h0000_00C1);
`else
    chk("stall_consume_01", 32'(bus.imm_value), 32'h0000_0001);
`endif

    // Asynchronous reset between edges with a prefix pending
    step(1'b1, 6'b000011, 2'b11, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid",   32'(bus.imm_valid),      32'd0);
    chk("arst_value",   32'(bus.imm_value),      32'd0);
    chk("arst_pending", 32'(bus.prefix_pending), 32'd0);
    chk("arst_ovf",     32'(bus.prefix_ovf),     32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 6'b000001, 2'b01, 1'b0, 1'b0);
    chk("post_rst_01", 32'(bus.imm_value), 32'h0000_0001);

    // Random mix, scoreboarded against the model
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 6'($urandom), 2'($urandom),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
